// File: rtl/cla_pkg.sv
// -----------------------------------------------------------------------------
// cla_pkg
// Shared definitions for the sequential carry-lookahead adder:
//   WORD_W  - width of the single CLA slice (one operand word per clock)
//   STATE_W - width of the sequencer state encoding
//   IDX_W   - width of the word index (covers up to 8 words)
//   state_e - sequencer states IDLE / RUN / DONE
// -----------------------------------------------------------------------------
package cla_pkg;

    localparam int WORD_W  = 16;
    localparam int STATE_W = 2;
    localparam int IDX_W   = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/cla16_slice.sv
// -----------------------------------------------------------------------------
// cla16_slice
// Combinational 16-bit carry-lookahead adder: four 4-bit lookahead groups
// with a second lookahead level across the group generate/propagate terms.
// Ports:
//   a, b  [15:0] - addends
//   cin          - carry in
//   sum   [15:0] - a + b + cin (mod 2^16)
//   cout         - carry out of bit 15 (c16)
// -----------------------------------------------------------------------------
module cla16_slice
    import cla_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              cin,
    output logic [WORD_W-1:0] sum,
    output logic              cout
);

    logic [WORD_W-1:0] w_g;   // bit generate
    logic [WORD_W-1:0] w_p;   // bit propagate
    logic [WORD_W-1:0] w_c;   // carry into each bit
    logic [3:0]        w_gg;  // group generate
    logic [3:0]        w_gp;  // group propagate
    logic [4:0]        w_gc;  // carry into each group, w_gc[4] = c16

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Group-level lookahead: every group carry depends only on cin and the
    // group G/P terms, so no carry ripples through the groups.
    assign w_gc[0] = cin;
    assign w_gc[1] = w_gg[0] | (w_gp[0] & cin);
    assign w_gc[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & cin);
    assign w_gc[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
                   | (w_gp[2] & w_gp[1] & w_gp[0] & cin);
    assign w_gc[4] = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
                   | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0])
                   | (w_gp[3] & w_gp[2] & w_gp[1] & w_gp[0] & cin);

    genvar k;
    generate
        for (k = 0; k < 4; k++) begin : g_grp
            assign w_gg[k] = w_g[4*k+3]
                           | (w_p[4*k+3] & w_g[4*k+2])
                           | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                           | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k]);
            assign w_gp[k] = &w_p[4*k+3:4*k];

            // Bit carries inside a group, expanded from the group carry-in.
            assign w_c[4*k]   = w_gc[k];
            assign w_c[4*k+1] = w_g[4*k] | (w_p[4*k] & w_gc[k]);
            assign w_c[4*k+2] = w_g[4*k+1] | (w_p[4*k+1] & w_g[4*k])
                              | (w_p[4*k+1] & w_p[4*k] & w_gc[k]);
            assign w_c[4*k+3] = w_g[4*k+2] | (w_p[4*k+2] & w_g[4*k+1])
                              | (w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                              | (w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_gc[k]);
        end
    endgenerate

    assign sum  = w_p ^ w_c;
    assign cout = w_gc[4];

endmodule

// File: rtl/cla_seq_adder.sv
// -----------------------------------------------------------------------------
// cla_seq_adder
// Multi-cycle W = 16*WORDS bit adder/subtractor that streams the operands
// through one 16-bit CLA slice, least-significant word first, keeping the
// inter-word carry in a register.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   in_valid / in_ready  - operand handshake (in_a, in_b, in_sub)
//   in_sub               - 1: A - B, 0: A + B
//   out_valid / out_ready- result handshake
//   out_sum              - W-bit result
//   out_cout             - carry out of the MSB (1 = no borrow on subtract)
//   out_ovf              - signed two's-complement overflow
//   busy                 - high while words are being processed
// -----------------------------------------------------------------------------
module cla_seq_adder
    import cla_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WORD_W*WORDS-1:0] in_a,
    input  logic [WORD_W*WORDS-1:0] in_b,
    input  logic                    in_sub,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WORD_W*WORDS-1:0] out_sum,
    output logic                    out_cout,
    output logic                    out_ovf,
    output logic                    busy
);

    localparam int               W        = WORD_W * WORDS;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [W-1:0]      r_a;
    logic [W-1:0]      r_b;       // holds ~B for subtraction
    logic [W-1:0]      r_sum;
    logic              r_carry;
    logic [IDX_W-1:0]  r_idx;
    logic              r_cout;
    logic              r_ovf;

    logic [WORD_W-1:0] w_word_sum;
    logic              w_c16;
    logic [W-1:0]      w_sum_top;
    logic              w_accept;
    logic              w_last;
    logic              w_ovf;

    cla16_slice u_slice (
        .a    (r_a[WORD_W-1:0]),
        .b    (r_b[WORD_W-1:0]),
        .cin  (r_carry),
        .sum  (w_word_sum),
        .cout (w_c16)
    );

    assign w_accept  = in_valid & in_ready;
    assign w_last    = (r_idx == LAST_IDX);
    // New word enters at the top of the result; after WORDS shifts the
    // first word computed has reached bit 0.
    assign w_sum_top = W'(w_word_sum) << (W - WORD_W);
    // Overflow of the top word: equal operand signs, different result sign.
    assign w_ovf     = (r_a[WORD_W-1] == r_b[WORD_W-1]) &&
                       (w_word_sum[WORD_W-1] != r_a[WORD_W-1]);

    // Sequencer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Sequencer next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_state_nxt = RUN;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = DONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Handshake and status outputs decoded from the state register
    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            IDLE:    in_ready  = 1'b1;
            RUN:     busy      = 1'b1;
            DONE:    out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    // Operand shift registers, carry, index and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= {W{1'b0}};
            r_b     <= {W{1'b0}};
            r_sum   <= {W{1'b0}};
            r_carry <= 1'b0;
            r_idx   <= {IDX_W{1'b0}};
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a     <= in_a;
                        // Subtraction is A + ~B + 1: invert B, seed carry.
                        r_b     <= in_sub ? ~in_b : in_b;
                        r_carry <= in_sub;
                        r_idx   <= {IDX_W{1'b0}};
                    end
                end
                RUN: begin
                    r_a     <= r_a >> WORD_W;
                    r_b     <= r_b >> WORD_W;
                    r_sum   <= (r_sum >> WORD_W) | w_sum_top;
                    r_carry <= w_c16;
                    r_idx   <= r_idx + 3'd1;
                    if (w_last) begin
                        r_cout <= w_c16;
                        r_ovf  <= w_ovf;
                    end
                end
                default: begin
                    r_idx <= r_idx;
                end
            endcase
        end
    end

    assign out_sum  = r_sum;
    assign out_cout = r_cout;
    assign out_ovf  = r_ovf;

endmodule
